// File: rtl/mul_flux_sched_if.sv
// ----------------------------------------------------------------------------
// mul_flux_sched_if
//
// Purpose:
//   Bundles the scheduler/datapath handshake of the multi-flux multiplier.
//   The scheduler sits on the master modport and drives the grant side. The
//   datapath (or a testbench) sits on the slave modport and drives the
//   request/consume side.
//
// Signals:
//   en           datapath -> sched   scheduler enable
//   eligible     datapath -> sched   per-stream "can operate now"
//   fire         datapath -> sched   one operation consumed on granted stream
//   last         datapath -> sched   qualifies fire: end of stream's block
//   grant        sched -> datapath   one-hot grant (zero when idle)
//   grant_valid  sched -> datapath   grant active
//   grant_tag    sched -> datapath   index of granted stream
//   burst_cnt    sched -> datapath   fires taken in the current grant
//   starve       sched -> datapath   per-stream starvation flag
//   proto_err    sched -> datapath   sticky protocol error
// ----------------------------------------------------------------------------
interface mul_flux_sched_if #(
    parameter int FLUX      = 2,
    parameter int TAG_WIDTH = (FLUX > 1) ? $clog2(FLUX) : 1,
    parameter int BURST     = 4
);
    localparam int CNT_W = $clog2(BURST + 1);

    logic                 en;
    logic [FLUX-1:0]      eligible;
    logic                 fire;
    logic                 last;

    logic [FLUX-1:0]      grant;
    logic                 grant_valid;
    logic [TAG_WIDTH-1:0] grant_tag;
    logic [CNT_W-1:0]     burst_cnt;
    logic [FLUX-1:0]      starve;
    logic                 proto_err;

    modport master (
        input  en,
        input  eligible,
        input  fire,
        input  last,
        output grant,
        output grant_valid,
        output grant_tag,
        output burst_cnt,
        output starve,
        output proto_err
    );

    modport slave (
        output en,
        output eligible,
        output fire,
        output last,
        input  grant,
        input  grant_valid,
        input  grant_tag,
        input  burst_cnt,
        input  starve,
        input  proto_err
    );
endinterface

// File: rtl/mul_flux_sched.sv
// ----------------------------------------------------------------------------
// mul_flux_sched
//
// Purpose:
//   Round-robin flux scheduler for the tagged multiplier datapath. A registered
//   grant rotates fairly between FLUX streams; each grant lasts at most BURST
//   accepted operations and is released early on end-of-block, on loss of
//   eligibility with no fire, or when the scheduler is disabled. On release
//   the next winner is searched starting just past the released stream and,
//   if one exists, granted at the same edge (no bubble). Per-stream wait
//   counters raise a starvation flag, and a fire seen with no active grant
//   sets a sticky protocol error.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-low reset
//   bus   mul_flux_sched_if.master (en/eligible/fire/last in,
//         grant/grant_valid/grant_tag/burst_cnt/starve/proto_err out)
//
// All outputs are flop outputs.
// ----------------------------------------------------------------------------
module mul_flux_sched #(
    parameter int FLUX         = 2,
    parameter int TAG_WIDTH    = (FLUX > 1) ? $clog2(FLUX) : 1,
    parameter int BURST        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    mul_flux_sched_if.master  bus
);
    localparam int CNT_W  = $clog2(BURST + 1);
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_GRANT = 1'b1;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [0:0]           r_state;
    logic [FLUX-1:0]      r_grant;
    logic                 r_grant_valid;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [TAG_WIDTH-1:0] r_ptr;
    logic [CNT_W-1:0]     r_cnt;
    logic [WAIT_W-1:0]    r_wait [FLUX];
    logic [FLUX-1:0]      r_starve;
    logic                 r_err;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [TAG_WIDTH-1:0] w_tag_inc;
    logic [TAG_WIDTH-1:0] w_start;
    logic                 w_found;
    logic [TAG_WIDTH-1:0] w_win;
    logic [FLUX-1:0]      w_win_onehot;
    logic                 w_tag_elig;
    logic                 w_last_beat;
    logic                 w_release;
    logic [WAIT_W-1:0]    w_wait_nxt [FLUX];

    // Modulo-FLUX increment of a stream index; collapses to 0 for FLUX=1.
    function automatic logic [TAG_WIDTH-1:0] wrap_inc(input logic [TAG_WIDTH-1:0] v);
        if (FLUX == 1) begin
            return '0;
        end
        if (int'(v) >= FLUX - 1) begin
            return '0;
        end
        return v + 1'b1;
    endfunction

    assign w_tag_inc = wrap_inc(r_tag);

    // While granted, the only search that matters is the one used on release,
    // which starts just past the current holder. In IDLE the stored pointer is
    // the start point. One search engine serves both cases.
    assign w_start = (r_state == S_GRANT) ? w_tag_inc : r_ptr;

    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 0; k < FLUX; k++) begin
            if (!w_found && bus.eligible[(int'(w_start) + k) % FLUX]) begin
                w_found = 1'b1;
                w_win   = TAG_WIDTH'((int'(w_start) + k) % FLUX);
            end
        end
    end

    always_comb begin
        w_win_onehot        = '0;
        w_win_onehot[w_win] = 1'b1;
    end

    assign w_tag_elig  = bus.eligible[r_tag];
    assign w_last_beat = (r_cnt == CNT_W'(BURST - 1));

    // Any combination of release causes collapses into one release; a fire in
    // the releasing cycle is simply absorbed since the count restarts anyway.
    assign w_release = (r_state == S_GRANT) &&
                       (!bus.en ||
                        (!w_tag_elig && !bus.fire) ||
                        (bus.fire && (bus.last || w_last_beat)));

    // Wait counters look at the grant held during the current cycle, so a
    // stream that is granted at this edge still counts this cycle as waiting.
    always_comb begin
        for (int i = 0; i < FLUX; i++) begin
            if (!bus.eligible[i] || r_grant[i]) begin
                w_wait_nxt[i] = '0;
            end else if (r_wait[i] == WAIT_W'(STARVE_LIMIT)) begin
                w_wait_nxt[i] = r_wait[i];
            end else begin
                w_wait_nxt[i] = r_wait[i] + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Grant state machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_tag         <= '0;
            r_ptr         <= '0;
            r_cnt         <= '0;
            r_err         <= 1'b0;
        end else begin
            if (r_state == S_IDLE) begin
                // A fire with nothing granted is a datapath protocol bug.
                if (bus.fire) begin
                    r_err <= 1'b1;
                end
                if (bus.en && w_found) begin
                    r_state       <= S_GRANT;
                    r_grant_valid <= 1'b1;
                    r_grant       <= w_win_onehot;
                    r_tag         <= w_win;
                    r_cnt         <= '0;
                end
            end else if (w_release) begin
                r_ptr <= w_tag_inc;
                if (bus.en && w_found) begin
                    // Back-to-back handover: no idle cycle between grants.
                    r_grant <= w_win_onehot;
                    r_tag   <= w_win;
                    r_cnt   <= '0;
                end else begin
                    // grant_tag keeps the last holder for debug visibility.
                    r_state       <= S_IDLE;
                    r_grant_valid <= 1'b0;
                    r_grant       <= '0;
                    r_cnt         <= '0;
                end
            end else if (bus.fire) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Starvation tracking
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FLUX; i++) begin
                r_wait[i] <= '0;
            end
            r_starve <= '0;
        end else begin
            for (int i = 0; i < FLUX; i++) begin
                r_wait[i]   <= w_wait_nxt[i];
                r_starve[i] <= (w_wait_nxt[i] == WAIT_W'(STARVE_LIMIT));
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.grant       = r_grant;
    assign bus.grant_valid = r_grant_valid;
    assign bus.grant_tag   = r_tag;
    assign bus.burst_cnt   = r_cnt;
    assign bus.starve      = r_starve;
    assign bus.proto_err   = r_err;

endmodule

// File: tb/tb_mul_flux_sched.sv
// ----------------------------------------------------------------------------
// tb_mul_flux_sched
//
// Directed scenarios followed by randomized traffic. A behavioural model of
// the scheduling rules (stream indices as integers, a plain winner search)
// advances at every clock edge; the outputs are compared against it each
// cycle, and scenario checkpoints are additionally pinned to literal values.
// ----------------------------------------------------------------------------
module tb_mul_flux_sched;
    localparam int FLUX         = 2;
    localparam int TAG_WIDTH    = 1;
    localparam int BURST        = 4;
    localparam int STARVE_LIMIT = 8;

    logic clk = 1'b0;
    logic rst;

    mul_flux_sched_if #(.FLUX(FLUX), .TAG_WIDTH(TAG_WIDTH), .BURST(BURST)) bus ();

    mul_flux_sched #(
        .FLUX(FLUX), .TAG_WIDTH(TAG_WIDTH), .BURST(BURST), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Model state
    bit              m_gv;
    int              m_tag;
    int              m_cnt;
    int              m_ptr;
    int              m_wait [FLUX];
    bit [FLUX-1:0]   m_starve;
    bit              m_err;

    int errs   = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_gv = 0; m_tag = 0; m_cnt = 0; m_ptr = 0; m_starve = '0; m_err = 0;
        for (int i = 0; i < FLUX; i++) m_wait[i] = 0;
    endtask

    // First eligible stream scanning start, start+1, ... (mod FLUX); -1 if none.
    function automatic int pick(input int start);
        for (int k = 0; k < FLUX; k++) begin
            if (bus.eligible[(start + k) % FLUX] == 1'b1) return (start + k) % FLUX;
        end
        return -1;
    endfunction

    task automatic model_edge();
        bit rel;
        int w;
        for (int i = 0; i < FLUX; i++) begin
            if (bus.eligible[i] == 1'b0 || (m_gv && m_tag == i)) m_wait[i] = 0;
            else if (m_wait[i] < STARVE_LIMIT) m_wait[i] = m_wait[i] + 1;
            m_starve[i] = (m_wait[i] == STARVE_LIMIT);
        end
        if (!m_gv) begin
            if (bus.fire) m_err = 1;
            w = pick(m_ptr);
            if (bus.en && w >= 0) begin
                m_gv = 1; m_tag = w; m_cnt = 0;
            end
        end else begin
            rel = !bus.en || (!bus.eligible[m_tag] && !bus.fire) ||
                  (bus.fire && (bus.last || m_cnt == BURST - 1));
            if (!rel) begin
                if (bus.fire) m_cnt = m_cnt + 1;
            end else begin
                m_ptr = (m_tag + 1) % FLUX;
                w = pick(m_ptr);
                if (bus.en && w >= 0) begin
                    m_tag = w; m_cnt = 0;
                end else begin
                    m_gv = 0; m_cnt = 0;
                end
            end
        end
    endtask

    task automatic compare();
        logic [FLUX-1:0] eg;
        eg = '0;
        if (m_gv) eg[m_tag] = 1'b1;
        check("grant",       32'(bus.grant),       32'(eg));
        check("grant_valid", 32'(bus.grant_valid), 32'(m_gv));
        check("grant_tag",   32'(bus.grant_tag),   32'(m_tag));
        check("burst_cnt",   32'(bus.burst_cnt),   32'(m_cnt));
        check("starve",      32'(bus.starve),      32'(m_starve));
        check("proto_err",   32'(bus.proto_err),   32'(m_err));
    endtask

    // One clock: model advances on the edge, outputs sampled 2 time units later.
    task automatic tick();
        @(posedge clk);
        if (rst) model_edge();
        #2;
        compare();
    endtask

    task automatic drive(input bit e, input bit [FLUX-1:0] el, input bit f, input bit l);
        bus.en = e; bus.eligible = el; bus.fire = f; bus.last = l;
    endtask

    task automatic reset_dut();
        rst = 1'b0;
        model_reset();
        drive(0, 2'b00, 0, 0);
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst = 1'b0;
        drive(0, 2'b00, 0, 0);
        model_reset();
        tick();
        tick();
        check("reset_gv",  32'(bus.grant_valid), 32'd0);
        check("reset_err", 32'(bus.proto_err),   32'd0);
        rst = 1'b1;

        // Rotation: 4 fires per grant, handover with no bubble.
        drive(1, 2'b11, 0, 0);
        tick();
        check("rot_first_gv",  32'(bus.grant_valid), 32'd1);
        check("rot_first_tag", 32'(bus.grant_tag),   32'd0);
        drive(1, 2'b11, 1, 0);
        tick(); tick(); tick();
        check("rot_cnt3", 32'(bus.burst_cnt), 32'd3);
        tick();
        check("rot_tag1", 32'(bus.grant_tag), 32'd1);
        check("rot_cnt0", 32'(bus.burst_cnt), 32'd0);
        check("rot_gv",   32'(bus.grant_valid), 32'd1);
        repeat (12) tick();

        // End of block.
        reset_dut();
        drive(1, 2'b11, 0, 0);
        tick();
        drive(1, 2'b11, 1, 0);
        tick();
        drive(1, 2'b11, 1, 1);
        tick();
        check("eob_tag1", 32'(bus.grant_tag), 32'd1);
        check("eob_cnt0", 32'(bus.burst_cnt), 32'd0);
        drive(1, 2'b01, 0, 0);
        tick();
        check("eob_back_tag0", 32'(bus.grant_tag), 32'd0);
        drive(1, 2'b01, 1, 1);
        tick();
        check("eob_regrant_tag0", 32'(bus.grant_tag),   32'd0);
        check("eob_regrant_gv",   32'(bus.grant_valid), 32'd1);

        // Eligibility drop and wrap-around search.
        drive(1, 2'b00, 0, 0);
        tick();
        check("drop_gv0", 32'(bus.grant_valid), 32'd0);
        drive(1, 2'b01, 0, 0);
        tick();
        check("wrap_gv1",  32'(bus.grant_valid), 32'd1);
        check("wrap_tag0", 32'(bus.grant_tag),   32'd0);

        // Starvation of stream 1 while stream 0 stalls.
        reset_dut();
        drive(1, 2'b11, 0, 0);
        repeat (7) tick();
        check("starve_pre", 32'(bus.starve), 32'd0);
        tick();
        check("starve_set", 32'(bus.starve),    32'b10);
        check("starve_tag", 32'(bus.grant_tag), 32'd0);
        drive(1, 2'b10, 0, 0);
        tick();
        check("starve_hand_tag", 32'(bus.grant_tag), 32'd1);
        check("starve_held",     32'(bus.starve),    32'b10);
        tick();
        check("starve_clr", 32'(bus.starve), 32'd0);

        // Protocol error is sticky.
        reset_dut();
        drive(0, 2'b00, 1, 0);
        tick();
        check("perr_set", 32'(bus.proto_err), 32'd1);
        drive(0, 2'b00, 0, 0);
        tick(); tick();
        check("perr_sticky", 32'(bus.proto_err), 32'd1);

        // Asynchronous reset mid-grant.
        drive(1, 2'b11, 0, 0);
        tick();
        rst = 1'b0;
        model_reset();
        #1;
        check("arst_gv",    32'(bus.grant_valid), 32'd0);
        check("arst_grant", 32'(bus.grant),       32'd0);
        check("arst_err",   32'(bus.proto_err),   32'd0);
        check("arst_cnt",   32'(bus.burst_cnt),   32'd0);
        compare();
        drive(1, 2'b10, 0, 0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_tag1", 32'(bus.grant_tag),   32'd1);
        check("post_rst_gv",   32'(bus.grant_valid), 32'd1);

        // Enable drop releases, re-enable restarts from stream 0.
        drive(0, 2'b11, 0, 0);
        tick();
        check("en_off_gv", 32'(bus.grant_valid), 32'd0);
        repeat (3) tick();
        drive(1, 2'b11, 0, 0);
        tick();
        check("en_on_tag0", 32'(bus.grant_tag),   32'd0);
        check("en_on_gv",   32'(bus.grant_valid), 32'd1);

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                model_reset();
                #1;
                compare();
                tick();
                rst = 1'b1;
            end
            bus.en       = ($urandom_range(0, 9) != 0);
            bus.eligible = 2'($urandom_range(0, 3));
            bus.fire     = m_gv ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 49) == 0);
            bus.last     = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
